// File: rtl/mem_requester_if.sv
// Core-side request/response and memory-side strobe signals of the memory requester.
// Handshakes: a request is taken on a posedge where reqValid && reqReady; a response is
// consumed on a posedge where respValid && respAccept; memory strobes are one-cycle pulses.
interface mem_requester_if #(parameter int ADDR_W = 16);
  logic              reqValid;
  logic              reqWrite;
  logic [ADDR_W-1:0] reqAddr;
  logic [ADDR_W-1:0] reqData;
  logic              reqReady;
  logic              respValid;
  logic              respAccept;
  logic [ADDR_W-1:0] respData;
  logic              respErr;
  logic              memRead;
  logic [ADDR_W-1:0] memIn;
  logic              memReady;
  logic [ADDR_W-1:0] memOut;
  logic              memWrite;
  logic [ADDR_W-1:0] memWriteAddr;
  logic [ADDR_W-1:0] memWriteData;
  logic [7:0]        loadCount;

  modport master (
    input  reqValid, reqWrite, reqAddr, reqData, respAccept, memReady, memOut,
    output reqReady, respValid, respData, respErr, memRead, memIn,
           memWrite, memWriteAddr, memWriteData, loadCount
  );

  modport slave (
    output reqValid, reqWrite, reqAddr, reqData, respAccept, memReady, memOut,
    input  reqReady, respValid, respData, respErr, memRead, memIn,
           memWrite, memWriteAddr, memWriteData, loadCount
  );
endinterface

// File: rtl/mem_requester.sv
// Single-outstanding load/store requester: issues one-cycle memory strobes, waits for read
// data with a timeout, and holds the response until the core accepts it.
module mem_requester #(
  parameter int TIMEOUT = 32,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_requester_if.master   bus,
  output logic [2:0]        fsm_state
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] data_q;
  logic [CNT_W-1:0]  wait_cnt;

  assign bus.reqReady = (state == IDLE);
  assign fsm_state    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      data_q           <= '0;
      wait_cnt         <= '0;
      bus.respValid    <= 1'b0;
      bus.respData     <= '0;
      bus.respErr      <= 1'b0;
      bus.memRead      <= 1'b0;
      bus.memIn        <= '0;
      bus.memWrite     <= 1'b0;
      bus.memWriteAddr <= '0;
      bus.memWriteData <= '0;
      bus.loadCount    <= 8'd0;
    end else begin
      // Strobes and their buses default low so each pulse lasts exactly one cycle.
      bus.memRead      <= 1'b0;
      bus.memIn        <= '0;
      bus.memWrite     <= 1'b0;
      bus.memWriteAddr <= '0;
      bus.memWriteData <= '0;
      case (state)
        IDLE: begin
          if (bus.reqValid) begin
            data_q <= bus.reqData;
            if (bus.reqWrite) begin
              state            <= WR_ISSUE;
              bus.memWrite     <= 1'b1;
              bus.memWriteAddr <= bus.reqAddr;
              bus.memWriteData <= bus.reqData;
            end else begin
              state       <= RD_ISSUE;
              bus.memRead <= 1'b1;
              bus.memIn   <= bus.reqAddr;
            end
          end
        end
        RD_ISSUE: begin
          state    <= RD_WAIT;
          wait_cnt <= '0;
        end
        RD_WAIT: begin
          // Data arriving in the same cycle the count expires still counts as success.
          if (bus.memReady) begin
            state         <= RESP;
            bus.respValid <= 1'b1;
            bus.respData  <= bus.memOut;
            bus.respErr   <= 1'b0;
            if (bus.loadCount != 8'hFF) bus.loadCount <= bus.loadCount + 8'd1;
          end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
            state         <= RESP;
            bus.respValid <= 1'b1;
            bus.respData  <= '1;
            bus.respErr   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WR_ISSUE: begin
          state         <= RESP;
          bus.respValid <= 1'b1;
          bus.respData  <= data_q;
          bus.respErr   <= 1'b0;
        end
        RESP: begin
          if (bus.respAccept) begin
            state         <= IDLE;
            bus.respValid <= 1'b0;
            bus.respErr   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester: inputs change and outputs are sampled on the falling edge.
module tb_mem_requester;
  localparam int TIMEOUT = 32;
  localparam int ADDR_W  = 16;

  logic       clk;
  logic       rst_n;
  logic [2:0] fsm_state;
  int         tests;
  int         fails;

  mem_requester_if #(.ADDR_W(ADDR_W)) bus ();

  mem_requester #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive_idle();
    bus.reqValid   = 1'b0;
    bus.reqWrite   = 1'b0;
    bus.reqAddr    = '0;
    bus.reqData    = '0;
    bus.respAccept = 1'b0;
    bus.memReady   = 1'b0;
    bus.memOut     = '0;
  endtask

  task automatic do_load(input logic [15:0] addr, input logic [15:0] data);
    bus.reqValid = 1'b1;
    bus.reqWrite = 1'b0;
    bus.reqAddr  = addr;
    @(negedge clk);
    bus.reqValid = 1'b0;
    @(negedge clk);
    bus.memReady = 1'b1;
    bus.memOut   = data;
    @(negedge clk);
    bus.memReady   = 1'b0;
    bus.respAccept = 1'b1;
    @(negedge clk);
    bus.respAccept = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (fsm_state !== 3'd0 || bus.reqReady !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: state=%0d reqReady=%b, want 0/1", fsm_state, bus.reqReady);
    end
    tests++;
    if ({bus.respValid, bus.respErr, bus.memRead, bus.memWrite} !== 4'b0 ||
        bus.respData !== 16'h0 || bus.memIn !== 16'h0 || bus.memWriteAddr !== 16'h0 ||
        bus.memWriteData !== 16'h0 || bus.loadCount !== 8'd0) begin
      fails++;
      $display("FAIL reset_outputs: rv=%b re=%b mr=%b mw=%b rd=%h lc=%0d, want all 0",
               bus.respValid, bus.respErr, bus.memRead, bus.memWrite, bus.respData, bus.loadCount);
    end
  endtask

  task automatic test_load();
    logic seen_bad;
    bus.reqValid = 1'b1;
    bus.reqWrite = 1'b0;
    bus.reqAddr  = 16'd5;
    @(negedge clk);  // cycle 1
    bus.reqValid = 1'b0;
    tests++;
    if (bus.memRead !== 1'b1 || bus.memIn !== 16'd5 || bus.memWrite !== 1'b0) begin
      fails++;
      $display("FAIL load_issue: memRead=%b memIn=%0d memWrite=%b, want 1/5/0",
               bus.memRead, bus.memIn, bus.memWrite);
    end
    seen_bad = 1'b0;
    for (int i = 2; i <= 13; i++) begin
      @(negedge clk);
      if (bus.memRead !== 1'b0 || bus.memIn !== 16'd0 || bus.respValid !== 1'b0) seen_bad = 1'b1;
    end
    tests++;
    if (seen_bad !== 1'b0) begin
      fails++;
      $display("FAIL load_wait: strobe or response seen during wait, want none");
    end
    bus.memReady = 1'b1;  // cycle 13
    bus.memOut   = 16'h00AB;
    @(negedge clk);       // cycle 14
    bus.memReady = 1'b0;
    bus.memOut   = 16'h0;
    tests++;
    if (bus.respValid !== 1'b1 || bus.respData !== 16'h00AB || bus.respErr !== 1'b0 ||
        bus.loadCount !== 8'd1) begin
      fails++;
      $display("FAIL load_resp: rv=%b data=%h err=%b lc=%0d, want 1/00ab/0/1",
               bus.respValid, bus.respData, bus.respErr, bus.loadCount);
    end
    bus.respAccept = 1'b1;
    @(negedge clk);
    bus.respAccept = 1'b0;
    tests++;
    if (bus.respValid !== 1'b0 || bus.reqReady !== 1'b1) begin
      fails++;
      $display("FAIL load_accept: rv=%b reqReady=%b, want 0/1", bus.respValid, bus.reqReady);
    end
  endtask

  task automatic test_store();
    bus.reqValid = 1'b1;
    bus.reqWrite = 1'b1;
    bus.reqAddr  = 16'd7;
    bus.reqData  = 16'h1234;
    @(negedge clk);
    bus.reqValid = 1'b0;
    bus.reqWrite = 1'b0;
    bus.reqData  = 16'h0;
    tests++;
    if (bus.memWrite !== 1'b1 || bus.memWriteAddr !== 16'd7 || bus.memWriteData !== 16'h1234 ||
        bus.memRead !== 1'b0 || bus.reqReady !== 1'b0) begin
      fails++;
      $display("FAIL store_issue: mw=%b addr=%0d data=%h mr=%b rr=%b, want 1/7/1234/0/0",
               bus.memWrite, bus.memWriteAddr, bus.memWriteData, bus.memRead, bus.reqReady);
    end
    @(negedge clk);
    tests++;
    if (bus.memWrite !== 1'b0 || bus.memWriteAddr !== 16'd0 || bus.memWriteData !== 16'd0 ||
        bus.respValid !== 1'b1 || bus.respData !== 16'h1234 || bus.respErr !== 1'b0 ||
        bus.loadCount !== 8'd1) begin
      fails++;
      $display("FAIL store_resp: mw=%b rv=%b data=%h err=%b lc=%0d, want 0/1/1234/0/1",
               bus.memWrite, bus.respValid, bus.respData, bus.respErr, bus.loadCount);
    end
    bus.respAccept = 1'b1;
    @(negedge clk);
    bus.respAccept = 1'b0;
  endtask

  task automatic test_timeout();
    logic early;
    bus.reqValid = 1'b1;
    bus.reqWrite = 1'b0;
    bus.reqAddr  = 16'd9;
    @(negedge clk);  // cycle 1: RD_ISSUE
    bus.reqValid = 1'b0;
    early = 1'b0;
    for (int i = 2; i <= 2 + TIMEOUT; i++) begin
      @(negedge clk);
      if (bus.respValid !== 1'b0) early = 1'b1;
    end
    tests++;
    if (early !== 1'b0) begin
      fails++;
      $display("FAIL timeout_early: response before %0d wait cycles", TIMEOUT + 1);
    end
    @(negedge clk);  // RD_WAIT entry + TIMEOUT + 1
    tests++;
    if (bus.respValid !== 1'b1 || bus.respErr !== 1'b1 || bus.respData !== 16'hFFFF) begin
      fails++;
      $display("FAIL timeout_resp: rv=%b err=%b data=%h, want 1/1/ffff",
               bus.respValid, bus.respErr, bus.respData);
    end
    bus.memReady = 1'b1;
    bus.memOut   = 16'h5555;
    @(negedge clk);
    bus.memReady = 1'b0;
    tests++;
    if (bus.respData !== 16'hFFFF || bus.respErr !== 1'b1 || bus.loadCount !== 8'd1 ||
        fsm_state !== 3'd4) begin
      fails++;
      $display("FAIL timeout_late_ready: data=%h err=%b lc=%0d st=%0d, want ffff/1/1/4",
               bus.respData, bus.respErr, bus.loadCount, fsm_state);
    end
    bus.respAccept = 1'b1;
    @(negedge clk);
    bus.respAccept = 1'b0;
    bus.memReady   = 1'b1;  // stray strobe while idle
    bus.memOut     = 16'h7777;
    @(negedge clk);
    bus.memReady = 1'b0;
    @(negedge clk);
    tests++;
    if (fsm_state !== 3'd0 || bus.respValid !== 1'b0 || bus.loadCount !== 8'd1) begin
      fails++;
      $display("FAIL stray_ready: st=%0d rv=%b lc=%0d, want 0/0/1",
               fsm_state, bus.respValid, bus.loadCount);
    end
  endtask

  task automatic test_ready_wins();
    bus.reqValid = 1'b1;
    bus.reqWrite = 1'b0;
    bus.reqAddr  = 16'd3;
    @(negedge clk);  // cycle 1
    bus.reqValid = 1'b0;
    for (int i = 2; i <= 1 + TIMEOUT; i++) @(negedge clk);
    @(negedge clk);  // last wait cycle, count equals TIMEOUT
    bus.memReady = 1'b1;
    bus.memOut   = 16'hBEEF;
    @(negedge clk);
    bus.memReady = 1'b0;
    tests++;
    if (bus.respValid !== 1'b1 || bus.respErr !== 1'b0 || bus.respData !== 16'hBEEF ||
        bus.loadCount !== 8'd2) begin
      fails++;
      $display("FAIL ready_wins: rv=%b err=%b data=%h lc=%0d, want 1/0/beef/2",
               bus.respValid, bus.respErr, bus.respData, bus.loadCount);
    end
    bus.respAccept = 1'b1;
    @(negedge clk);
    bus.respAccept = 1'b0;
  endtask

  task automatic test_backpressure();
    logic unstable;
    bus.reqValid = 1'b1;
    bus.reqWrite = 1'b1;
    bus.reqAddr  = 16'd20;
    bus.reqData  = 16'hCAFE;
    @(negedge clk);  // WR_ISSUE
    bus.reqAddr = 16'd21;
    bus.reqData = 16'hD00D;  // reqValid stays high as pressure
    unstable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.respValid !== 1'b1 || bus.respData !== 16'hCAFE || bus.reqReady !== 1'b0 ||
          bus.memWrite !== 1'b0 || bus.memRead !== 1'b0) unstable = 1'b1;
    end
    tests++;
    if (unstable !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_hold: response changed or request taken while held");
    end
    bus.respAccept = 1'b1;
    @(negedge clk);  // IDLE; request not taken on the accept edge
    bus.respAccept = 1'b0;
    tests++;
    if (bus.respValid !== 1'b0 || bus.memWrite !== 1'b0 || bus.reqReady !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_accept: rv=%b mw=%b rr=%b, want 0/0/1",
               bus.respValid, bus.memWrite, bus.reqReady);
    end
    @(negedge clk);
    bus.reqValid = 1'b0;
    bus.reqWrite = 1'b0;
    tests++;
    if (bus.memWrite !== 1'b1 || bus.memWriteAddr !== 16'd21 || bus.memWriteData !== 16'hD00D) begin
      fails++;
      $display("FAIL backpressure_next: mw=%b addr=%0d data=%h, want 1/21/d00d",
               bus.memWrite, bus.memWriteAddr, bus.memWriteData);
    end
    @(negedge clk);
    bus.respAccept = 1'b1;
    @(negedge clk);
    bus.respAccept = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic resp_seen;
    bus.reqValid = 1'b1;
    bus.reqWrite = 1'b0;
    bus.reqAddr  = 16'd11;
    @(negedge clk);
    bus.reqValid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (fsm_state !== 3'd0 || bus.respValid !== 1'b0 || bus.memRead !== 1'b0 ||
        bus.loadCount !== 8'd0 || bus.respData !== 16'd0 || bus.memIn !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid_wait: st=%0d rv=%b mr=%b lc=%0d rd=%h, want all 0",
               fsm_state, bus.respValid, bus.memRead, bus.loadCount, bus.respData);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.memReady = 1'b1;
    bus.memOut   = 16'h4242;
    @(negedge clk);
    bus.memReady = 1'b0;
    resp_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.respValid !== 1'b0 || fsm_state !== 3'd0) resp_seen = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (resp_seen !== 1'b0 || bus.loadCount !== 8'd0) begin
      fails++;
      $display("FAIL reset_late_ready: response=%b lc=%0d, want 0/0", resp_seen, bus.loadCount);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 254; i++) do_load(16'(i), 16'(i + 100));
    tests++;
    if (bus.loadCount !== 8'd254 || bus.respData !== 16'd353) begin
      fails++;
      $display("FAIL sat_254: lc=%0d data=%0d, want 254/353", bus.loadCount, bus.respData);
    end
    do_load(16'd500, 16'd1);
    tests++;
    if (bus.loadCount !== 8'd255) begin
      fails++;
      $display("FAIL sat_255: lc=%0d, want 255", bus.loadCount);
    end
    for (int i = 0; i < 5; i++) do_load(16'(600 + i), 16'(i));
    tests++;
    if (bus.loadCount !== 8'd255) begin
      fails++;
      $display("FAIL sat_260: lc=%0d, want 255", bus.loadCount);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_ready_wins();
    test_backpressure();
    test_reset_mid_wait();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_requester.md
MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 Parameter TIMEOUT, default 32: max cycles waited for memReady after memRead before abort.
REQ-002 Parameter ADDR_W, default 16: address/data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 reqValid  input  1  core request present.
REQ-006 reqWrite  input  1  1=store, 0=load; sampled with reqValid.
REQ-007 reqAddr  input  16  request address.
REQ-008 reqData  input  16  store data.
REQ-009 reqReady  output  1  combinational; high only in IDLE.
REQ-010 respValid  output  1  response present; held until respAccept.
REQ-011 respAccept  input  1  core consumes response.
REQ-012 respData  output  16  load data, or store data echoed for stores.
REQ-013 respErr  output  1  response is a timeout abort; valid with respValid.
REQ-014 memRead  output  1  one-cycle read strobe to memory.
REQ-015 memIn  output  16  read address; valid while memRead=1.
REQ-016 memReady  input  1  one-cycle read-data strobe from memory.
REQ-017 memOut  input  16  read data; valid only while memReady=1.
REQ-018 memWrite  output  1  one-cycle write strobe.
REQ-019 memWriteAddr  output  16  write address; valid while memWrite=1.
REQ-020 memWriteData  output  16  write data; valid while memWrite=1.
REQ-021 loadCount  output  8  completed non-error loads, saturating at 255.

Function
REQ-022 States IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP; one outstanding request max.
REQ-023 IDLE, reqValid=1 at posedge: latch addr/data; reqWrite=0 -> RD_ISSUE, reqWrite=1 -> WR_ISSUE.
REQ-024 RD_ISSUE: memRead=1, memIn=latched addr for exactly that cycle; next state RD_WAIT; wait counter cleared to 0.
REQ-025 RD_WAIT: counter increments each cycle; memReady=1 -> capture memOut into respData, respErr=0, -> RESP.
REQ-026 RD_WAIT: counter reaches TIMEOUT with memReady=0 -> respData=16'hFFFF, respErr=1, -> RESP.
REQ-027 memReady and timeout in same cycle: memReady wins, respErr=0.
REQ-028 WR_ISSUE: memWrite=1, memWriteAddr/memWriteData=latched values for exactly that cycle; respData=latched data, respErr=0; -> RESP.
REQ-029 RESP: respValid=1; respData/respErr stable; respAccept=1 -> IDLE next cycle; otherwise hold indefinitely.
REQ-030 No new request accepted in the RESP cycle where respAccept=1; earliest next accept is the following IDLE cycle.
REQ-031 memReady outside RD_WAIT (stray or late after timeout) ignored; no state or counter change.
REQ-032 memRead and memWrite never high together; each high for at most one cycle per request.
REQ-033 loadCount increments by 1 on each RD_WAIT->RESP with respErr=0; holds at 255.
REQ-034 memIn, memWriteAddr, memWriteData are 0 when their strobe is low.

Reset
REQ-035 rst_n=0 asynchronously forces IDLE, counters 0, and respValid, respErr, memRead, memWrite, loadCount, respData, memIn, memWriteAddr, memWriteData to 0.
REQ-036 Reset mid-read discards the request; a memReady arriving after release is ignored per REQ-031.

Verification
REQ-037 Load: reqValid, reqWrite=0, reqAddr=5 at cycle 0; memory model returns 16'h00AB on memReady 12 cycles after memRead -> memRead=1/memIn=5 in cycle 1 only; respValid=1, respData=16'h00AB, respErr=0 the cycle after memReady; loadCount=1.
REQ-038 Store: reqWrite=1, reqAddr=7, reqData=16'h1234 -> memWrite=1 for one cycle with addr 7/data 16'h1234; respValid next cycle with respData=16'h1234.
REQ-039 Timeout: no memReady after read -> respValid with respErr=1 and respData=16'hFFFF TIMEOUT+1 cycles after RD_WAIT entry; late memReady ignored; loadCount unchanged.
REQ-040 Backpressure: hold respAccept=0 for 10 cycles -> respValid and respData stable, reqReady=0 and reqValid ignored throughout; accepted on respAccept.
REQ-041 Reset mid-wait: rst_n=0 in RD_WAIT -> all outputs 0 immediately; memReady after release produces no respValid.
REQ-042 Saturation: 260 successful loads -> loadCount=255.
